baud_tick_gen: RTL and testbench

Programmable fractional tick generator for the UART datapath; it is the parametrised successor to the fixed-ratio clock divider. It produces single-cycle enable pulses (`os_tick`, `mid_tick`, `bit_tick`) in the `clk` domain. It never generates a derived clock. The divisor is runtime-loadable with a fractional part, and the phase can be restarted for RX start-bit alignment.

---
 rtl/baud_tick_if.sv | 26 ++
 rtl/baud_tick_gen.sv | 116 +++++++++++
 tb/tb_baud_tick_gen.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/baud_tick_if.sv
// Control and tick bundle for the UART baud tick generator.
// The master drives divisor and phase control; the slave returns the tick pulses.
interface baud_tick_if #(
  parameter int DIV_WIDTH  = 16,
  parameter int FRAC_WIDTH = 4
);
  logic                  enable;
  logic [DIV_WIDTH-1:0]  div_int;
  logic [FRAC_WIDTH-1:0] div_frac;
  logic                  div_load;
  logic                  sync_restart;
  logic                  os_tick;
  logic                  mid_tick;
  logic                  bit_tick;
  logic                  cfg_err;

  modport master (
    output enable, div_int, div_frac, div_load, sync_restart,
    input  os_tick, mid_tick, bit_tick, cfg_err
  );

  modport slave (
    input  enable, div_int, div_frac, div_load, sync_restart,
    output os_tick, mid_tick, bit_tick, cfg_err
  );
endinterface

// File: rtl/baud_tick_gen.sv
// Fractional baud tick generator: single-cycle os/mid/bit enable pulses in the clk domain,
// with a double-buffered runtime divisor and a phase restart for start-bit alignment.
module baud_tick_gen #(
  parameter int DIV_WIDTH        = 16,
  parameter int FRAC_WIDTH       = 4,
  parameter int OVERSAMPLE       = 16,
  parameter int DEFAULT_DIV_INT  = 27,
  parameter int DEFAULT_DIV_FRAC = 2
) (
  input  logic        clk,
  input  logic        reset,
  baud_tick_if.slave  bus
);
  localparam int                    OS_W     = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [DIV_WIDTH-1:0]  DEF_INT  = DIV_WIDTH'(DEFAULT_DIV_INT);
  localparam logic [FRAC_WIDTH-1:0] DEF_FRAC = FRAC_WIDTH'(DEFAULT_DIV_FRAC);
  localparam logic [OS_W-1:0]       MID_IDX  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]       BIT_IDX  = OS_W'(OVERSAMPLE - 1);

  if ((OVERSAMPLE < 2) || ((OVERSAMPLE & (OVERSAMPLE - 1)) != 0)) begin : g_bad_oversample
    $error("baud_tick_gen: OVERSAMPLE must be a power of two and at least 2");
  end
  if (DEFAULT_DIV_INT < 2) begin : g_bad_default_div
    $error("baud_tick_gen: DEFAULT_DIV_INT must be at least 2");
  end

  logic [DIV_WIDTH-1:0]  sh_int_r;
  logic [FRAC_WIDTH-1:0] sh_frac_r;
  logic [FRAC_WIDTH-1:0] act_frac_r;
  logic [DIV_WIDTH-1:0]  cnt_r;
  logic [FRAC_WIDTH-1:0] acc_r;
  logic [OS_W-1:0]       os_cnt_r;
  logic                  os_tick_r;
  logic                  mid_tick_r;
  logic                  bit_tick_r;
  logic                  cfg_err_r;

  logic                  load_ok_s;
  logic [DIV_WIDTH-1:0]  sh_int_nx_s;
  logic [FRAC_WIDTH-1:0] sh_frac_nx_s;
  logic [FRAC_WIDTH:0]   acc_sum_s;
  logic [DIV_WIDTH-1:0]  carry_s;

  // Next shadow value and fractional accumulation for the current period boundary.
  always_comb begin
    load_ok_s    = 1'b0;
    sh_int_nx_s  = sh_int_r;
    sh_frac_nx_s = sh_frac_r;
    if (bus.div_load && (bus.div_int >= DIV_WIDTH'(2))) begin
      load_ok_s    = 1'b1;
      sh_int_nx_s  = bus.div_int;
      sh_frac_nx_s = bus.div_frac;
    end else begin
      load_ok_s    = 1'b0;
    end
    acc_sum_s = {1'b0, acc_r} + {1'b0, act_frac_r};
    carry_s   = {{(DIV_WIDTH-1){1'b0}}, acc_sum_s[FRAC_WIDTH]};
  end

  // Shadow divisor capture and sticky rejection flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sh_int_r  <= DEF_INT;
      sh_frac_r <= DEF_FRAC;
      cfg_err_r <= 1'b0;
    end else begin
      sh_int_r  <= sh_int_nx_s;
      sh_frac_r <= sh_frac_nx_s;
      if (bus.div_load) begin
        cfg_err_r <= ~load_ok_s;
      end
    end
  end

  // Period counter, fractional carry and oversample phase; the active integer
  // divisor is only ever consumed as the cnt reload, so it is not kept separately.
  always_ff @(posedge clk) begin
    if (!reset) begin
      act_frac_r <= DEF_FRAC;
      cnt_r      <= DEF_INT - DIV_WIDTH'(1);
      acc_r      <= {FRAC_WIDTH{1'b0}};
      os_cnt_r   <= {OS_W{1'b0}};
      os_tick_r  <= 1'b0;
      mid_tick_r <= 1'b0;
      bit_tick_r <= 1'b0;
    end else begin
      os_tick_r  <= 1'b0;
      mid_tick_r <= 1'b0;
      bit_tick_r <= 1'b0;
      if (bus.sync_restart) begin
        // Restart wins over a coincident boundary and picks up a same-cycle load.
        act_frac_r <= sh_frac_nx_s;
        cnt_r      <= sh_int_nx_s - DIV_WIDTH'(1);
        acc_r      <= {FRAC_WIDTH{1'b0}};
        os_cnt_r   <= {OS_W{1'b0}};
      end else if (bus.enable) begin
        if (cnt_r != {DIV_WIDTH{1'b0}}) begin
          cnt_r <= cnt_r - DIV_WIDTH'(1);
        end else begin
          acc_r      <= acc_sum_s[FRAC_WIDTH-1:0];
          act_frac_r <= sh_frac_r;
          cnt_r      <= sh_int_r - DIV_WIDTH'(1) + carry_s;
          os_cnt_r   <= os_cnt_r + OS_W'(1);
          os_tick_r  <= 1'b1;
          mid_tick_r <= (os_cnt_r == MID_IDX);
          bit_tick_r <= (os_cnt_r == BIT_IDX);
        end
      end
    end
  end

  assign bus.os_tick  = os_tick_r;
  assign bus.mid_tick = mid_tick_r;
  assign bus.bit_tick = bit_tick_r;
  assign bus.cfg_err  = cfg_err_r;
endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen with OVERSAMPLE=4 and default 27/2 divisor.
// All driving and sampling happens on the falling edge of clk.
module tb_baud_tick_gen;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;

  baud_tick_if #(.DIV_WIDTH(16), .FRAC_WIDTH(4)) bus ();

  baud_tick_gen #(
    .DIV_WIDTH(16), .FRAC_WIDTH(4), .OVERSAMPLE(4),
    .DEFAULT_DIV_INT(27), .DEFAULT_DIV_FRAC(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Cycles from now until os_tick is seen (-1 on timeout); counts mid/bit pulses without os_tick.
  task automatic wait_tick(output int n, output int stray);
    n = -1;
    stray = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (bus.os_tick === 1'b1) begin
        n = i;
        break;
      end else if ((bus.mid_tick !== 1'b0) || (bus.bit_tick !== 1'b0)) begin
        stray++;
      end
    end
  endtask

  // Load a divisor, optionally with a restart, for one cycle.
  task automatic apply(input int di, input int df, input logic rs);
    bus.div_int      = 16'(di);
    bus.div_frac     = 4'(df);
    bus.div_load     = 1'b1;
    bus.sync_restart = rs;
    @(negedge clk);
    bus.div_load     = 1'b0;
    bus.sync_restart = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    int s;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.os_tick !== 1'b0) begin n_fail++; $display("FAIL reset_os_tick got %b want 0", bus.os_tick); end
    n_cmp++; if (bus.mid_tick !== 1'b0) begin n_fail++; $display("FAIL reset_mid_tick got %b want 0", bus.mid_tick); end
    n_cmp++; if (bus.bit_tick !== 1'b0) begin n_fail++; $display("FAIL reset_bit_tick got %b want 0", bus.bit_tick); end
    n_cmp++; if (bus.cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_err got %b want 0", bus.cfg_err); end
    reset = 1'b1;
    wait_tick(n, s);
    n_cmp++; if (n !== 27) begin n_fail++; $display("FAIL reset_first_tick got %0d want 27", n); end
    wait_tick(n, s);
    n_cmp++; if (n !== 27) begin n_fail++; $display("FAIL reset_second_period got %0d want 27", n); end
  endtask

  task automatic test_period();
    int n;
    int s;
    int stray_total;
    stray_total = 0;
    apply(4, 0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      wait_tick(n, s);
      stray_total += s;
      n_cmp++; if (n !== 4) begin n_fail++; $display("FAIL period_len[%0d] got %0d want 4", i, n); end
      n_cmp++; if (bus.mid_tick !== ((i % 4) == 1)) begin n_fail++; $display("FAIL period_mid[%0d] got %b want %b", i, bus.mid_tick, ((i % 4) == 1)); end
      n_cmp++; if (bus.bit_tick !== ((i % 4) == 3)) begin n_fail++; $display("FAIL period_bit[%0d] got %b want %b", i, bus.bit_tick, ((i % 4) == 3)); end
    end
    n_cmp++; if (stray_total !== 0) begin n_fail++; $display("FAIL period_stray got %0d want 0", stray_total); end
  endtask

  task automatic test_fractional();
    int n;
    int s;
    int exp_len;
    int total;
    total = 0;
    apply(4, 8, 1'b1);
    for (int i = 0; i < 32; i++) begin
      wait_tick(n, s);
      total += n;
      exp_len = (i == 0) ? 4 : (((i % 2) == 1) ? 4 : 5);
      n_cmp++; if (n !== exp_len) begin n_fail++; $display("FAIL frac_len[%0d] got %0d want %0d", i, n, exp_len); end
    end
    n_cmp++; if ((total < 143) || (total > 145)) begin n_fail++; $display("FAIL frac_span got %0d want 144+-1", total); end
  endtask

  task automatic test_div_change();
    int t[$];
    int exp_t[4];
    exp_t = '{4, 10, 16, 22};
    apply(4, 0, 1'b1);
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (bus.os_tick === 1'b1) t.push_back(c);
      if (c == 2) begin
        bus.div_int  = 16'd6;
        bus.div_frac = 4'd0;
        bus.div_load = 1'b1;
      end else if (c == 3) begin
        bus.div_load = 1'b0;
      end
    end
    n_cmp++; if (t.size() < 4) begin n_fail++; $display("FAIL divchg_count got %0d want >=4", t.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < t.size()) begin
        n_cmp++; if (t[i] !== exp_t[i]) begin n_fail++; $display("FAIL divchg_tick[%0d] got %0d want %0d", i, t[i], exp_t[i]); end
      end
    end
  endtask

  task automatic test_invalid();
    int n;
    int s;
    apply(1, 0, 1'b0);
    n_cmp++; if (bus.cfg_err !== 1'b1) begin n_fail++; $display("FAIL invalid_cfg_err got %b want 1", bus.cfg_err); end
    wait_tick(n, s);
    wait_tick(n, s);
    n_cmp++; if (n !== 6) begin n_fail++; $display("FAIL invalid_period got %0d want 6", n); end
    apply(3, 0, 1'b0);
    n_cmp++; if (bus.cfg_err !== 1'b0) begin n_fail++; $display("FAIL valid_cfg_err got %b want 0", bus.cfg_err); end
    wait_tick(n, s);
    wait_tick(n, s);
    n_cmp++; if (n !== 3) begin n_fail++; $display("FAIL valid_period got %0d want 3", n); end
  endtask

  task automatic test_back_to_back();
    int t[$];
    int m[$];
    int b[$];
    int exp_t[6];
    exp_t = '{4, 12, 16, 30, 34, 38};
    apply(4, 0, 1'b1);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.os_tick === 1'b1) t.push_back(c);
      if (bus.mid_tick === 1'b1) m.push_back(c);
      if (bus.bit_tick === 1'b1) b.push_back(c);
      if (c == 7) bus.sync_restart = 1'b1;
      else if (c == 8) bus.sync_restart = 1'b0;
      else if (c == 18) bus.enable = 1'b0;
      else if (c == 28) bus.enable = 1'b1;
    end
    n_cmp++; if (t.size() !== 6) begin n_fail++; $display("FAIL collide_count got %0d want 6", t.size()); end
    for (int i = 0; i < 6; i++) begin
      if (i < t.size()) begin
        n_cmp++; if (t[i] !== exp_t[i]) begin n_fail++; $display("FAIL collide_tick[%0d] got %0d want %0d", i, t[i], exp_t[i]); end
      end
    end
    n_cmp++; if ((m.size() !== 1) || (m[0] !== 16)) begin n_fail++; $display("FAIL collide_mid got count %0d want single at 16", m.size()); end
    n_cmp++; if ((b.size() !== 1) || (b[0] !== 34)) begin n_fail++; $display("FAIL collide_bit got count %0d want single at 34", b.size()); end
  endtask

  task automatic test_reset_mid();
    int n;
    int s;
    int exp_len;
    apply(0, 0, 1'b0);
    n_cmp++; if (bus.cfg_err !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_cfg_err got %b want 1", bus.cfg_err); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if ({bus.os_tick, bus.mid_tick, bus.bit_tick, bus.cfg_err} !== 4'b0000) begin
      n_fail++; $display("FAIL rstmid_outputs got %b want 0000", {bus.os_tick, bus.mid_tick, bus.bit_tick, bus.cfg_err});
    end
    reset = 1'b1;
    wait_tick(n, s);
    n_cmp++; if (n !== 27) begin n_fail++; $display("FAIL rstmid_first_tick got %0d want 27", n); end
    for (int i = 1; i <= 8; i++) begin
      wait_tick(n, s);
      exp_len = (i == 8) ? 28 : 27;
      n_cmp++; if (n !== exp_len) begin n_fail++; $display("FAIL rstmid_period[%0d] got %0d want %0d", i, n, exp_len); end
    end
  endtask

  initial begin
    n_cmp            = 0;
    n_fail           = 0;
    reset            = 1'b0;
    bus.enable       = 1'b1;
    bus.div_int      = 16'd0;
    bus.div_frac     = 4'd0;
    bus.div_load     = 1'b0;
    bus.sync_restart = 1'b0;
    @(negedge clk);
    test_reset();
    test_period();
    test_fractional();
    test_div_change();
    test_invalid();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
